// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, two-flop RXD synchronizer, mid-bit sampling, one-cycle result strobes
//   clk       system clock, rising edge
//   n_rst     synchronous active-low reset
//   RXD       asynchronous serial input, idles high
//   rx_data   last correctly framed byte, held until the next good frame
//   rx_valid  one-cycle pulse when rx_data updates
//   frame_err one-cycle pulse when the stop bit samples low
//   busy      high whenever the receiver is not idle
module uart_rx #(
   parameter int unsigned CLKS_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       n_rst,
   input  logic       RXD,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       frame_err,
   output logic       busy
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] H_M1 = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] C_M1 = CW'(CLKS_PER_BIT - 1);
   typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;
   state_t        state_q, state_d;
   logic          s1_q, s2_q;
   logic [1:0]    rdy_q, rdy_d;
   logic          armed_q, armed_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    bidx_q, bidx_d;
   logic [7:0]    shreg_q, shreg_d;
   logic [7:0]    rx_data_q, rx_data_d;
   logic          rx_valid_q, rx_valid_d;
   logic          ferr_q, ferr_d;
   // s2 holds reset value, not the line, for two edges after reset; rdy marks when it is genuine.
   // armed requires a genuine high before the first start, so a line held low through reset is ignored.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      bidx_d     = bidx_q;
      shreg_d    = shreg_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = 1'b0;
      ferr_d     = 1'b0;
      rdy_d      = {rdy_q[0], 1'b1};
      armed_d    = armed_q | (rdy_q[1] & s2_q);
      case (state_q)
         IDLE: begin
            state_d = (armed_q && !s2_q) ? START : IDLE;
            cnt_d   = '0;
         end
         START: begin
            cnt_d   = (cnt_q == H_M1) ? '0 : cnt_q + 1'b1;
            bidx_d  = '0;
            state_d = (cnt_q != H_M1) ? START : (s2_q ? IDLE : DATA);
         end
         DATA: begin
            cnt_d = (cnt_q == C_M1) ? '0 : cnt_q + 1'b1;
            if (cnt_q == C_M1) begin
               shreg_d = {s2_q, shreg_q[7:1]};
               bidx_d  = bidx_q + 1'b1;
               state_d = (bidx_q == 3'd7) ? STOP : DATA;
            end
         end
         STOP: begin
            cnt_d = (cnt_q == C_M1) ? '0 : cnt_q + 1'b1;
            if (cnt_q == C_M1) begin
               rx_valid_d = s2_q;
               ferr_d     = !s2_q;
               rx_data_d  = s2_q ? shreg_q : rx_data_q;
               state_d    = s2_q ? IDLE : BRK;
            end
         end
         BRK:     state_d = s2_q ? IDLE : BRK;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state_q    <= IDLE;
         s1_q       <= 1'b1;
         s2_q       <= 1'b1;
         rdy_q      <= '0;
         armed_q    <= 1'b0;
         cnt_q      <= '0;
         bidx_q     <= '0;
         shreg_q    <= '0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         ferr_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         s1_q       <= RXD;
         s2_q       <= s1_q;
         rdy_q      <= rdy_d;
         armed_q    <= armed_d;
         cnt_q      <= cnt_d;
         bidx_q     <= bidx_d;
         shreg_q    <= shreg_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         ferr_q     <= ferr_d;
      end
   end
   assign rx_data   = rx_data_q;
   assign rx_valid  = rx_valid_q;
   assign frame_err = ferr_q;
   assign busy      = (state_q != IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized bench for uart_rx, checked against an edge-indexed frame model of the serial line
module tb_uart_rx;
   localparam int C    = 16;
   localparam int H    = C / 2;
   localparam int MAXC = 60000;
   logic       clk = 1'b0;
   logic       n_rst = 1'b0;
   logic       rxd = 1'b1;
   logic [7:0] rx_data;
   logic       rx_valid, frame_err, busy;
   int         n_cmp = 0;
   int         n_bad = 0;
   int         cyc = 0;
   bit         rxd_a [MAXC];
   bit         rst_a [MAXC];
   bit         v_a   [MAXC];
   bit         f_a   [MAXC];
   bit         b_a   [MAXC];
   logic [7:0] d_a   [MAXC];
   bit         eb_a  [MAXC];
   bit         ev_a  [MAXC];
   logic [7:0] ed_a  [MAXC];
   int         exp_t[$], exp_k[$], exp_d[$];
   int         obs_t[$], obs_k[$], obs_d[$];
   uart_rx #(.CLKS_PER_BIT(C)) dut (
      .clk(clk), .n_rst(n_rst), .RXD(rxd), .rx_data(rx_data),
      .rx_valid(rx_valid), .frame_err(frame_err), .busy(busy)
   );
   always #5 clk = ~clk;
   always @(posedge clk) if (cyc < MAXC) begin
      rxd_a[cyc] = rxd;
      rst_a[cyc] = n_rst;
   end
   always @(negedge clk) if (cyc < MAXC) begin
      v_a[cyc] = rx_valid;
      f_a[cyc] = frame_err;
      b_a[cyc] = busy;
      d_a[cyc] = rx_data;
      cyc++;
   end
   task automatic check(input string tag, input int unsigned got, input int unsigned exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask
   task automatic hold(input logic v, input int n);
      rxd = v;
      repeat (n) @(negedge clk);
   endtask
   // frame: start, 8 data LSB first, stop of stop_len cycles at stop_v; optional 2-cycle reset at offset rst_at
   task automatic send(input logic [7:0] b, input int stop_len, input logic stop_v, input int rst_at);
      for (int i = 0; i < 9 * C + stop_len; i++) begin
         rxd   = (i < C) ? 1'b0 : (i < 9 * C) ? b[i / C - 1] : stop_v;
         n_rst = !(rst_at >= 0 && i >= rst_at && i < rst_at + 2);
         @(negedge clk);
      end
      n_rst = 1'b1;
   endtask
   function automatic int find_v(input bit v, input int from, input int to);
      for (int i = from; i < to; i++) if (rxd_a[i] == v) return i;
      return -1;
   endfunction
   function automatic void mark_busy(input int from, input int to);
      for (int i = from; i < to; i++) eb_a[i] = 1'b1;
   endfunction
   // Indices are edges; line value at index i reaches the FSM at edge i+2. A frame whose line falls
   // at index l is judged at l+H (start), l+H+(k+1)C (data), l+H+9C (stop); results show at +2.
   function automatic void build_model(input int n);
      int t, a, b, p, h, l, s, j;
      logic [7:0] by;
      logic [7:0] cur;
      t = 0;
      while (t < n) begin
         if (!rst_a[t]) begin t++; continue; end
         a = t;
         b = t;
         while (b < n && rst_a[b]) b++;
         h = find_v(1'b1, a, b);
         p = (h < 0) ? b : h + 1;
         while (p < b) begin
            l = find_v(1'b0, p, b);
            if (l < 0 || l + 2 >= b) break;
            if (l + H + 2 >= b) begin mark_busy(l + 2, b); break; end
            if (rxd_a[l + H]) begin
               mark_busy(l + 2, l + H + 2);
               p = l + H + 1;
               continue;
            end
            s = l + H + 9 * C;
            if (s + 2 >= b) begin mark_busy(l + 2, b); break; end
            for (int k = 0; k < 8; k++) by[k] = rxd_a[l + H + (k + 1) * C];
            exp_t.push_back(s + 2);
            exp_k.push_back(rxd_a[s] ? 0 : 1);
            exp_d.push_back(rxd_a[s] ? int'(by) : 0);
            if (rxd_a[s]) begin
               ev_a[s + 2] = 1'b1;
               ed_a[s + 2] = by;
               mark_busy(l + 2, s + 2);
               p = s + 1;
            end else begin
               j = find_v(1'b1, s + 1, b);
               if (j < 0 || j + 2 >= b) begin mark_busy(l + 2, b); break; end
               mark_busy(l + 2, j + 2);
               p = j + 1;
            end
         end
         t = b;
      end
      cur = 8'h00;
      for (int i = 0; i < n; i++) begin
         cur = !rst_a[i] ? 8'h00 : ev_a[i] ? ed_a[i] : cur;
         ed_a[i] = cur;
      end
   endfunction
   initial begin
      int n, bad_b, bad_d, both, m, sel;
      repeat (3) @(negedge clk);
      check("rst_data", rx_data, 8'h00);
      check("rst_valid", rx_valid, 0);
      check("rst_ferr", frame_err, 0);
      check("rst_busy", busy, 0);
      rxd   = 1'b0;
      n_rst = 1'b1;
      repeat (40) @(negedge clk);
      check("held_low_busy", busy, 0);
      hold(1'b1, 20);
      send(8'hA5, C, 1'b1, -1);
      hold(1'b1, 20);
      check("a5_data", rx_data, 8'hA5);
      hold(1'b0, 3);
      hold(1'b1, 30);
      check("glitch_idle", busy, 0);
      send(8'h3C, 40, 1'b0, -1);
      check("ferr_hold", rx_data, 8'hA5);
      check("ferr_break", busy, 1);
      hold(1'b1, 20);
      send(8'h81, C, 1'b1, -1);
      hold(1'b1, 10);
      check("after_ferr", rx_data, 8'h81);
      send(8'h00, C, 1'b1, -1);
      send(8'hFF, C, 1'b1, -1);
      send(8'h55, C, 1'b1, -1);
      hold(1'b1, 10);
      send(8'hF0, C, 1'b1, 5 * C + 4);
      hold(1'b1, 20);
      send(8'h12, C, 1'b1, -1);
      hold(1'b1, 10);
      check("mid_rst", rx_data, 8'h12);
      for (int i = 0; i < 30; i++) begin
         sel = $urandom_range(0, 9);
         if (sel == 0) begin
            hold(1'b0, $urandom_range(1, H - 1));
            hold(1'b1, $urandom_range(H + 2, 3 * H));
         end else if (sel == 1) begin
            send(8'($urandom), C, 1'b1, $urandom_range(0, 10 * C - 3));
            hold(1'b1, $urandom_range(0, 20));
         end else if (sel == 2) begin
            send(8'($urandom), $urandom_range(10, 50), 1'b0, -1);
            hold(1'b1, $urandom_range(1, 20));
         end else send(8'($urandom), $urandom_range(C, C + 20), 1'b1, -1);
      end
      for (int i = 0; i < 256; i++) send(8'(i), C, 1'b1, -1);
      hold(1'b1, 20);
      n = cyc;
      build_model(n);
      bad_b = 0;
      bad_d = 0;
      both  = 0;
      for (int i = 0; i < n; i++) begin
         bad_b += (b_a[i] != eb_a[i]) ? 1 : 0;
         bad_d += (d_a[i] !== ed_a[i]) ? 1 : 0;
         both  += (v_a[i] && f_a[i]) ? 1 : 0;
         if (v_a[i] || f_a[i]) begin
            obs_t.push_back(i);
            obs_k.push_back(v_a[i] ? 0 : 1);
            obs_d.push_back(v_a[i] ? int'(d_a[i]) : 0);
         end
      end
      check("busy_cycles_bad", bad_b, 0);
      check("data_cycles_bad", bad_d, 0);
      check("strobe_overlap", both, 0);
      check("event_count", obs_t.size(), exp_t.size());
      m = (obs_t.size() < exp_t.size()) ? obs_t.size() : exp_t.size();
      for (int i = 0; i < m; i++) begin
         check($sformatf("ev%0d_time", i), obs_t[i], exp_t[i]);
         check($sformatf("ev%0d_kind", i), obs_k[i], exp_k[i]);
         check($sformatf("ev%0d_data", i), obs_d[i], exp_d[i]);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
